// File: rtl/stream_demux_1to2.sv
// ============================================================================
// Module   : stream_demux_1to2
// Purpose  : Registered 1-to-2 stream demultiplexer, 2-entry FIFO per channel.
//            Optional delivered-word counters when STREAM_DEMUX_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux_1to2 #(
    parameter int SIZE = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [SIZE-1:0] data_i,
    input  logic            select_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [SIZE-1:0] data0_o,
    output logic            valid0_o,
    input  logic            ready0_i,
    output logic [SIZE-1:0] data1_o,
    output logic            valid1_o,
    input  logic            ready1_i
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [15:0]     cnt0_o,
    output logic [15:0]     cnt1_o
`endif
);

    logic [1:0]      w_space;
    logic [1:0]      w_valid;
    logic [1:0]      w_cons_ready;
    logic [SIZE-1:0] w_head [2];
`ifdef STREAM_DEMUX_CNT_EN
    logic [15:0]     w_dcnt [2];
`endif

    assign w_cons_ready = {ready1_i, ready0_i};

    // Acceptance depends only on the selected channel's occupancy, never on consumer readies.
    assign ready_o = w_space[select_i];

    generate
        for (genvar k = 0; k < 2; k++) begin : g_ch
            logic [SIZE-1:0] r_mem [2];
            logic            r_wp;
            logic            r_rp;
            logic [1:0]      r_occ;
            logic            w_push;
            logic            w_pop;

            assign w_space[k] = (r_occ != 2'd2);
            assign w_valid[k] = (r_occ != 2'd0);
            assign w_head[k]  = r_mem[r_rp];
            assign w_push     = valid_i && ready_o && (select_i == (k != 0));
            assign w_pop      = w_valid[k] && w_cons_ready[k];

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_mem[0] <= '0;
                    r_mem[1] <= '0;
                    r_wp     <= 1'b0;
                    r_rp     <= 1'b0;
                    r_occ    <= 2'd0;
                end else begin
                    if (w_push) begin
                        r_mem[r_wp] <= data_i;
                        r_wp        <= ~r_wp;
                    end
                    if (w_pop) begin
                        r_rp <= ~r_rp;
                    end
                    // Push+pop together leaves occupancy unchanged.
                    case ({w_push, w_pop})
                        2'b10:   r_occ <= r_occ + 2'd1;
                        2'b01:   r_occ <= r_occ - 2'd1;
                        default: r_occ <= r_occ;
                    endcase
                end
            end

`ifdef STREAM_DEMUX_CNT_EN
            logic [15:0] r_dcnt;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_dcnt <= 16'd0;
                end else if (w_pop) begin
                    r_dcnt <= r_dcnt + 16'd1;
                end
            end

            assign w_dcnt[k] = r_dcnt;
`endif
        end
    endgenerate

    assign data0_o  = w_head[0];
    assign valid0_o = w_valid[0];
    assign data1_o  = w_head[1];
    assign valid1_o = w_valid[1];

`ifdef STREAM_DEMUX_CNT_EN
    assign cnt0_o = w_dcnt[0];
    assign cnt1_o = w_dcnt[1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_1to2.sv
// ============================================================================
// Module   : tb_stream_demux_1to2
// Purpose  : Self-checking bench for stream_demux_1to2 (vector table, queue
//            reference model with random traffic, reset and counter sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_demux_1to2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_i;
    logic        select_i, valid_i, ready_o;
    logic [31:0] data0_o, data1_o;
    logic        valid0_o, valid1_o, ready0_i, ready1_i;
`ifdef STREAM_DEMUX_CNT_EN
    logic [15:0] cnt0_o, cnt1_o;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stream_demux_1to2 #(.SIZE(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .data_i   (data_i),
        .select_i (select_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data0_o  (data0_o),
        .valid0_o (valid0_o),
        .ready0_i (ready0_i),
        .data1_o  (data1_o),
        .valid1_o (valid1_o),
        .ready1_i (ready1_i)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .cnt0_o   (cnt0_o),
        .cnt1_o   (cnt1_o)
`endif
    );

    typedef struct packed {
        logic        v;
        logic        sel;
        logic [31:0] d;
        logic        r0;
        logic        r1;
        logic        e_rdy;
        logic        e_v0;
        logic        e_v1;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [31:0] d,
                         input logic r0, input logic r1);
        valid_i  = v;
        select_i = sel;
        data_i   = d;
        ready0_i = r0;
        ready1_i = r1;
    endtask

    // Hold reset across edges, check the reset state, release between edges.
    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid0", {31'b0, valid0_o}, 32'd0);
        chk("rst_valid1", {31'b0, valid1_o}, 32'd0);
        chk("rst_data0", data0_o, 32'd0);
        chk("rst_data1", data1_o, 32'd0);
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        rst_n = 1'b1;
    endtask

    // Reference model: one queue per channel, plus delivered-word tallies.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [15:0] m_c0, m_c1;

    initial begin
        logic        v, sel, r0, r1, exp_rdy, pend;
        logic [31:0] d;

        tbl[0]  = '{1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h5A5A5A5A};
        tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 32'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd1, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 32'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd2, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd3, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'hC1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 32'hC2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hC1, 32'h0};
        tbl[14] = '{1'b1, 1'b1, 32'h77, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hC1, 32'h0};
        tbl[15] = '{1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC1, 32'h77};
        tbl[16] = '{1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hC1, 32'h0};
        tbl[17] = '{1'b1, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC2, 32'h10};
        tbl[18] = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h11};
        tbl[19] = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h11};
        tbl[20] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};

        do_reset();

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
            #1;
            chk($sformatf("tbl%0d_ready", i), {31'b0, ready_o}, {31'b0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_valid0", i), {31'b0, valid0_o}, {31'b0, tbl[i].e_v0});
            chk($sformatf("tbl%0d_valid1", i), {31'b0, valid1_o}, {31'b0, tbl[i].e_v1});
            if (tbl[i].e_v0) chk($sformatf("tbl%0d_data0", i), data0_o, tbl[i].e_d0);
            if (tbl[i].e_v1) chk($sformatf("tbl%0d_data1", i), data1_o, tbl[i].e_d1);
            @(posedge clk);
            #1;
        end

        // Random traffic against the queue model.
        do_reset();
        q0.delete();
        q1.delete();
        m_c0 = 16'd0;
        m_c1 = 16'd0;
        pend = 1'b0;
        v = 1'b0; sel = 1'b0; d = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend) begin
                v   = ($urandom_range(0, 3) != 0);
                sel = 1'($urandom_range(0, 1));
                d   = $urandom;
            end
            r0 = ($urandom_range(0, 2) == 0);
            r1 = ($urandom_range(0, 2) != 0);
            drive(v, sel, d, r0, r1);
            #1;
            exp_rdy = sel ? (q1.size() < 2) : (q0.size() < 2);
            chk("rnd_ready", {31'b0, ready_o}, {31'b0, exp_rdy});
            chk("rnd_valid0", {31'b0, valid0_o}, {31'b0, q0.size() != 0});
            chk("rnd_valid1", {31'b0, valid1_o}, {31'b0, q1.size() != 0});
            if (q0.size() != 0) chk("rnd_data0", data0_o, q0[0]);
            if (q1.size() != 0) chk("rnd_data1", data1_o, q1[0]);
`ifdef STREAM_DEMUX_CNT_EN
            chk("rnd_cnt0", {16'b0, cnt0_o}, {16'b0, m_c0});
            chk("rnd_cnt1", {16'b0, cnt1_o}, {16'b0, m_c1});
`endif
            @(posedge clk);
            if (q0.size() != 0 && r0) begin void'(q0.pop_front()); m_c0++; end
            if (q1.size() != 0 && r1) begin void'(q1.pop_front()); m_c1++; end
            if (v && exp_rdy) begin
                if (sel) q1.push_back(d);
                else     q0.push_back(d);
            end
            pend = v && !exp_rdy;
            #1;
        end

        // Fill both FIFOs, then assert reset between edges.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 1'(j / 2), 32'h100 + 32'(j), 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("full_ready0", {31'b0, ready_o}, 32'd0);
        chk("full_valid0", {31'b0, valid0_o}, 32'd1);
        chk("full_data1", data1_o, 32'h102);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid0", {31'b0, valid0_o}, 32'd0);
        chk("async_valid1", {31'b0, valid1_o}, 32'd0);
        chk("async_data0", data0_o, 32'd0);
        chk("async_data1", data1_o, 32'd0);
        chk("async_ready_sel0", {31'b0, ready_o}, 32'd1);
        select_i = 1'b1;
        #1;
        chk("async_ready_sel1", {31'b0, ready_o}, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid0", {31'b0, valid0_o}, 32'd0);
        chk("post_rst_valid1", {31'b0, valid1_o}, 32'd0);

`ifdef STREAM_DEMUX_CNT_EN
        // 65537 deliveries on channel 0 wrap the counter to 1.
        do_reset();
        for (int n = 0; n < 65537; n++) begin
            drive(1'b1, 1'b0, 32'(n), 1'b1, 1'b1);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("cnt0_wrap", {16'b0, cnt0_o}, 32'd1);
        chk("cnt1_idle", {16'b0, cnt1_o}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
